// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
//   Shared definitions for the sequenced N-to-2**N decoder:
//     - dec_state_e : FSM state encoding (IDLE / HOLD / SWEEP)
//     - MAX_N       : largest supported select width
//     - MAX_DWELL   : largest supported dwell length in cycles
//     - DWELL_CNT_W : dwell counter width, sized to hold MAX_DWELL-1
// ---------------------------------------------------------------------------
package decoder_pkg;

    localparam int MAX_N       = 8;
    localparam int MAX_DWELL   = 255;
    localparam int DWELL_CNT_W = $clog2(MAX_DWELL + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SWEEP = 2'd2
    } dec_state_e;

endpackage

// File: rtl/decoder_dwell_timer.sv
// ---------------------------------------------------------------------------
// decoder_dwell_timer
//   Counts cycles while a sweep is running and emits a one-cycle step pulse
//   every DWELL cycles, telling the decoder to advance its index.
//
//   Ports:
//     clk   in  1  clock, rising edge
//     rst   in  1  asynchronous active-high reset, clears the count
//     clear in  1  restart the dwell from zero (load); overrides run
//     run   in  1  count this cycle
//     step  out 1  high on the cycle the DWELL-th count completes
// ---------------------------------------------------------------------------
module decoder_dwell_timer
    import decoder_pkg::*;
#(
    parameter int DWELL = 4
)
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic step
);

    if (DWELL < 1 || DWELL > MAX_DWELL) begin : g_bad_dwell
        $error("decoder_dwell_timer: DWELL out of range");
    end

    localparam logic [DWELL_CNT_W-1:0] LAST = DWELL_CNT_W'(DWELL - 1);

    logic [DWELL_CNT_W-1:0] cnt_q;
    logic [DWELL_CNT_W-1:0] cnt_d;
    logic                   at_last;

    assign at_last = (cnt_q == LAST);

    // A clear in the same cycle means the dwell is being restarted, so the
    // pending step must not fire.
    assign step = run && !clear && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = at_last ? '0 : cnt_q + DWELL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// ---------------------------------------------------------------------------
// decoder_nto2n_seq
//   Registered N-to-2**N decoder with a hold mode and an automatic sweep.
//   A select word accepted in IDLE/HOLD is decoded and held; sweep_start
//   walks the decoded index 0,1,..,2**N-1,0,.. holding each for DWELL
//   cycles until sweep_stop freezes it.
//
//   Build option: define DECODER_ACTIVE_LOW_EN for a one-cold output with an
//   all-ones inactive pattern; otherwise the output is one-hot with an
//   all-zeros inactive pattern.
//
//   Ports:
//     clk         in  1      clock, rising edge
//     rst         in  1      asynchronous active-high reset
//     en          in  1      output enable; 0 shows the inactive pattern
//     in_valid    in  1      select word offered
//     in_ready    out 1      select word can be accepted (not sweeping)
//     in          in  N      select index
//     sweep_start in  1      pulse: start or restart the sweep
//     sweep_stop  in  1      pulse: stop the sweep (wins over start)
//     out         out 2**N   registered decode
//     out_valid   out 1      out carries a decoded value
//     busy        out 1      registered, high while sweeping
// ---------------------------------------------------------------------------
module decoder_nto2n_seq
    import decoder_pkg::*;
#(
    parameter int N     = 2,
    parameter int DWELL = 4
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in,
    input  logic            sweep_start,
    input  logic            sweep_stop,
    output logic [2**N-1:0] out,
    output logic            out_valid,
    output logic            busy
);

    if (N < 1 || N > MAX_N) begin : g_bad_n
        $error("decoder_nto2n_seq: N out of range");
    end

    localparam int OUT_W = 2**N;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] INACTIVE = '1;
`else
    localparam logic [OUT_W-1:0] INACTIVE = '0;
`endif

    function automatic logic [OUT_W-1:0] decode(input logic [N-1:0] sel);
        logic [OUT_W-1:0] hot;
        hot = OUT_W'(1) << sel;
`ifdef DECODER_ACTIVE_LOW_EN
        return ~hot;
`else
        return hot;
`endif
    endfunction

    dec_state_e        state_q;
    dec_state_e        state_d;
    logic [N-1:0]      idx_q;
    logic [N-1:0]      idx_d;
    logic [OUT_W-1:0]  out_q;
    logic [OUT_W-1:0]  out_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic              busy_q;
    logic              busy_d;

    logic              start_req;
    logic              accept;
    logic              timer_clear;
    logic              timer_run;
    logic              dwell_step;

    // Stop beats start whenever both are pulsed together.
    assign start_req = sweep_start && !sweep_stop;

    assign in_ready  = (state_q != ST_SWEEP);

    // A sweep_start in the same cycle swallows the offered word even though
    // in_ready still reads 1.
    assign accept    = in_valid && in_ready && !sweep_start;

    assign timer_run = (state_q == ST_SWEEP);

    decoder_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .run   (timer_run),
        .step  (dwell_step)
    );

    // Next-state and index selection
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (start_req) begin
                    state_d     = ST_SWEEP;
                    idx_d       = '0;
                    timer_clear = 1'b1;
                end else if (accept) begin
                    state_d     = ST_HOLD;
                    idx_d       = in;
                end
            end
            ST_SWEEP: begin
                if (sweep_stop) begin
                    // Freeze at the index currently shown; a step due this
                    // cycle is discarded.
                    state_d     = ST_HOLD;
                    timer_clear = 1'b1;
                end else if (sweep_start) begin
                    idx_d       = '0;
                    timer_clear = 1'b1;
                end else if (dwell_step) begin
                    // N-bit addition wraps 2**N-1 back to 0 by itself.
                    idx_d       = idx_q + N'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                idx_d       = '0;
                timer_clear = 1'b1;
            end
        endcase
    end

    // Output stage: computed from the next state so out follows the index
    // with one register of latency and en takes effect on the next edge.
    always_comb begin
        out_valid_d = en && (state_d != ST_IDLE);
        out_d       = out_valid_d ? decode(idx_d) : INACTIVE;
        busy_d      = (state_d == ST_SWEEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            out_q       <= INACTIVE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
